// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic       comparison;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [6:0] alu_opcode;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, comparison, mem_ready,
    output mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, result_src,
           alu_src_a, alu_src_b, alu_opcode, illegal, state
  );

  modport slave (
    output opcode, comparison, mem_ready,
    input  mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, result_src,
           alu_src_a, alu_src_b, alu_opcode, illegal, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control with a
// ready handshake on memory. Outputs are decoded from the state register.
module mc_control_fsm (
  input logic               clk,
  input logic               rst_n,
  mc_control_fsm_if.master  bus
);

  localparam logic [6:0] AddOpcode = 7'b0010111;
  localparam logic [6:0] OpR       = 7'b0110011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExAlu  = 4'd2,
    StExAddr = 4'd3,
    StExBr   = 4'd4,
    StExJal  = 4'd5,
    StExJalr = 4'd6,
    StMemRd  = 4'd7,
    StMemWr  = 4'd8,
    StWbAlu  = 4'd9,
    StWbMem  = 4'd10,
    StTrap   = 4'd15
  } state_e;

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpR, OpImm, OpLui, OpAuipc: state_d = StExAlu;
          OpLoad, OpStore:            state_d = StExAddr;
          OpBranch:                   state_d = StExBr;
          OpJal:                      state_d = StExJal;
          OpJalr:                     state_d = StExJalr;
          default:                    state_d = StTrap;
        endcase
      end
      StExAlu:  state_d = StWbAlu;
      StExAddr: state_d = (bus.opcode == OpLoad) ? StMemRd : StMemWr;
      StExBr:   state_d = StFetch;
      StExJal:  state_d = StFetch;
      StExJalr: state_d = StFetch;
      StMemRd:  if (bus.mem_ready) state_d = StWbMem;
      StMemWr:  if (bus.mem_ready) state_d = StFetch;
      StWbAlu:  state_d = StFetch;
      StWbMem:  state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // rst_n masks every output combinationally so no strobe escapes in a reset cycle.
  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_opcode = AddOpcode;
    bus.illegal    = 1'b0;
    bus.state      = 4'd0;
    if (rst_n) begin
      bus.state = state_q;
      case (state_q)
        StFetch: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        StDecode: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
        end
        StExAlu: begin
          bus.alu_opcode = bus.opcode;
          bus.alu_src_a  = (bus.opcode == OpAuipc) ? 2'b01 : 2'b10;
          bus.alu_src_b  = (bus.opcode == OpR) ? 2'b00 : 2'b01;
        end
        StExAddr: begin
          bus.alu_opcode = bus.opcode;
          bus.alu_src_a  = 2'b10;
          bus.alu_src_b  = 2'b01;
        end
        StExBr: begin
          bus.alu_opcode = bus.opcode;
          bus.alu_src_a  = 2'b10;
          bus.pc_src     = 1'b1;
          bus.pc_write   = bus.comparison;
        end
        StExJal: begin
          bus.pc_write   = 1'b1;
          bus.pc_src     = 1'b1;
          bus.reg_write  = 1'b1;
          bus.result_src = 2'b10;
        end
        StExJalr: begin
          bus.alu_opcode = bus.opcode;
          bus.alu_src_a  = 2'b10;
          bus.alu_src_b  = 2'b01;
          bus.pc_write   = 1'b1;
          bus.reg_write  = 1'b1;
          bus.result_src = 2'b10;
        end
        StMemRd: bus.mem_read = 1'b1;
        StMemWr: bus.mem_write = 1'b1;
        StWbAlu: bus.reg_write = 1'b1;
        StWbMem: begin
          bus.reg_write  = 1'b1;
          bus.result_src = 2'b01;
        end
        StTrap:  bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle sequencer for the RV32I core. Decodes the latched instruction opcode and steps the datapath through the FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK phases. It drives every datapath enable and mux select, and it also drives the opcode fed to the shared ALU, forcing an add where the datapath needs address or PC arithmetic. It sits between the instruction register and the datapath; memory accesses use a ready handshake.

## Interface
- ADD_OPCODE, 7'b0010111: opcode driven to the ALU to force a plain add (AUIPC class; the ALU ignores func3/func7 for it).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  IR[6:0] of the latched instruction (valid from DECODE on).
- comparison  in  1  ALU branch-condition result.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  latch IR and old_pc (= PC) this edge.
- pc_write  out  1  update PC this edge.
- pc_src  out  1  next PC: 0 = ALU result (combinational), 1 = ALUOut register.
- reg_write  out  1  register-file write of rd.
- result_src  out  2  rd data: 00 ALUOut, 01 memory data, 10 PC.
- alu_src_a  out  2  ALU A: 00 PC, 01 old_pc, 10 rs1 (reg A).
- alu_src_b  out  2  ALU B: 00 rs2 (reg B), 01 immediate, 10 constant 4.
- alu_opcode  out  7  opcode presented to the ALU.
- illegal  out  1  unsupported opcode trapped.
- state  out  4  current state encoding (debug/verification).

## Operation
- States and encodings: FETCH=0, DECODE=1, EX_ALU=2, EX_ADDR=3, EX_BR=4, EX_JAL=5, EX_JALR=6, MEM_RD=7, MEM_WR=8, WB_ALU=9, WB_MEM=10, TRAP=15. All other encodings are illegal and go to FETCH.
- Any output not listed for a state is 0. In that case alu_src_a/alu_src_b are 00 and alu_opcode is ADD_OPCODE.
- FETCH: mem_read=1, alu_src_a=00, alu_src_b=10, alu_opcode=ADD_OPCODE. If mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise hold.
- DECODE: alu_src_a=01, alu_src_b=01, add. ALUOut then holds the branch/JAL target. Dispatch on opcode:
  - 0110011, 0010011, 0110111, 0010111 → EX_ALU.
  - 0000011, 0100011 → EX_ADDR.
  - 1100011 → EX_BR.
  - 1101111 → EX_JAL.
  - 1100111 → EX_JALR.
  - anything else → TRAP.
- EX_ALU: alu_opcode=opcode. alu_src_a=01 if AUIPC, else 10. alu_src_b=00 if R-type, else 01. Go to WB_ALU.
- EX_ADDR: alu_src_a=10, alu_src_b=01, alu_opcode=opcode. Go to MEM_RD for a load, MEM_WR for a store.
- EX_BR: alu_src_a=10, alu_src_b=00, alu_opcode=opcode, pc_src=1, pc_write=comparison. Go to FETCH.
- EX_JAL: pc_write=1, pc_src=1, reg_write=1, result_src=10. rd receives the pre-update PC (old_pc+4). Go to FETCH.
- EX_JALR: alu_src_a=10, alu_src_b=01, alu_opcode=opcode, pc_write=1, pc_src=0, reg_write=1, result_src=10. Go to FETCH. The datapath clears bit 0 of the target.
- MEM_RD: mem_read=1. Hold until mem_ready, then go to WB_MEM.
- MEM_WR: mem_write=1. Hold until mem_ready, then go to FETCH.
- WB_ALU: reg_write=1, result_src=00. Go to FETCH.
- WB_MEM: reg_write=1, result_src=01. Go to FETCH.
- TRAP: illegal=1, no strobes. Stays in TRAP until reset.

## Timing
- While rst_n=0 at an edge: state becomes FETCH. During any cycle with rst_n=0, all outputs are forced to 0, alu_opcode=ADD_OPCODE, and state reads 0.
- Reset mid-operation: the in-flight instruction is abandoned with no reg/PC/memory write in the reset cycle. FETCH restarts on the first cycle with rst_n=1.
- Outputs are Moore-decoded from state. The exceptions are the FETCH ir_write/pc_write (gated by mem_ready) and the EX_BR pc_write (gated by comparison), which are combinational.
- Latency with zero memory wait:
  - R/I/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL, JALR: 3 cycles.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Request signals stay asserted and steady while waiting.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- At most one of mem_read and mem_write is high in any cycle.
- reg_write is high for at most one cycle per instruction.

## Test plan
- add (opcode 0110011), mem_ready=1 → state sequence 0,1,2,9. reg_write=1 only in cycle 4 with result_src=00. pc_write only in cycle 1.
- lw with mem_ready low for 2 cycles in MEM_RD → sequence 0,1,3,7,7,7,10. mem_read stays high through the 3 MEM_RD cycles. reg_write with result_src=01 in the last cycle.
- beq with comparison=1, then comparison=0 → EX_BR gives pc_write=1 with pc_src=1 in the first case and pc_write=0 in the second. Both take 3 cycles.
- jal (1101111) → EX_JAL asserts pc_write, pc_src=1, reg_write and result_src=10 in the same cycle, then returns to FETCH.
- opcode 0000000 → DECODE goes to TRAP. illegal=1 and state=15 held for 20 cycles with no strobes. rst_n=0 for one edge returns to state 0.
- rst_n=0 asserted during MEM_WR → no mem_write in the reset cycle. state=0 on the next cycle, and mem_read=1 once rst_n=1.
